// File: rtl/pipe_sequencer.sv
// Debug-link run/step/pause sequencer that gates a pipeline and drains it after HALT.
// Build option: define CYCLE_COUNTER_EN to implement the enabled-cycle counter on o_cycle_count.
module pipe_sequencer #(
    parameter int CMD_W        = 8,
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_cmd_valid,
    input  logic [CMD_W-1:0] i_cmd,
    output logic             o_cmd_ready,
    input  logic             i_halt_detected,
    output logic             o_pipe_enable,
    output logic             o_pc_hold,
    output logic             o_report_valid,
    input  logic             i_report_ready,
    output logic             o_done,
    output logic [2:0]       o_state,
    output logic [CNT_W-1:0] o_cycle_count
);

    localparam logic [CMD_W-1:0] CMD_RUN   = CMD_W'(8'h52);
    localparam logic [CMD_W-1:0] CMD_STEP  = CMD_W'(8'h53);
    localparam logic [CMD_W-1:0] CMD_PAUSE = CMD_W'(8'h48);
    localparam logic [CMD_W-1:0] CMD_CLEAR = CMD_W'(8'h43);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_STEP   = 3'd2,
        S_DRAIN  = 3'd3,
        S_REPORT = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_halted;
    logic [DW-1:0]   r_drain_cnt;
    logic            w_accept;
    logic            w_set_halted;
    logic            w_clear;
    logic            w_drain_last;

    // Every output is a pure decode of the state register.
    assign o_cmd_ready    = (r_state == S_IDLE) || (r_state == S_RUN) || (r_state == S_DONE);
    assign o_pipe_enable  = (r_state == S_RUN) || (r_state == S_STEP) || (r_state == S_DRAIN);
    assign o_pc_hold      = (r_state == S_DRAIN);
    assign o_report_valid = (r_state == S_REPORT);
    assign o_done         = (r_state == S_DONE);
    assign o_state        = r_state;

    assign w_accept     = i_cmd_valid && o_cmd_ready;
    assign w_drain_last = (r_drain_cnt == DRAIN_LAST);

    always_comb begin
        w_next       = r_state;
        w_set_halted = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && i_cmd == CMD_RUN)       w_next = S_RUN;
                else if (w_accept && i_cmd == CMD_STEP) w_next = S_STEP;
            end
            S_RUN: begin
                if (i_halt_detected)                     w_next = S_DRAIN;
                else if (w_accept && i_cmd == CMD_PAUSE) w_next = S_REPORT;
            end
            S_STEP: begin
                w_next = i_halt_detected ? S_DRAIN : S_REPORT;
            end
            S_DRAIN: begin
                if (w_drain_last) begin
                    w_next       = S_REPORT;
                    w_set_halted = 1'b1;
                end
            end
            S_REPORT: begin
                if (i_report_ready) w_next = r_halted ? S_DONE : S_IDLE;
            end
            S_DONE: begin
                if (w_accept && i_cmd == CMD_CLEAR) begin
                    w_next  = S_IDLE;
                    w_clear = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_halted    <= 1'b0;
            r_drain_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_clear)           r_halted <= 1'b0;
            else if (w_set_halted) r_halted <= 1'b1;
            // Counter rests at zero outside DRAIN so every drain starts fresh.
            if (r_state == S_DRAIN && !w_drain_last) r_drain_cnt <= r_drain_cnt + DW'(1);
            else                                     r_drain_cnt <= '0;
        end
    end

`ifdef CYCLE_COUNTER_EN
    logic [CNT_W-1:0] r_cycle_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_cycle_cnt <= '0;
        else if (w_clear)
            r_cycle_cnt <= '0;
        else if (o_pipe_enable && (r_cycle_cnt != '1))
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
    end

    assign o_cycle_count = r_cycle_cnt;
`else
    assign o_cycle_count = '0;
`endif

endmodule

// File: doc/pipe_sequencer.md
PIPE_SEQUENCER -- requirements
Module: pipe_sequencer

Interface
REQ-001 SHALL have parameter CMD_W, default 8, command byte width.
REQ-002 SHALL have parameter CNT_W, default 32, cycle counter width.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 4, pipeline cycles run after HALT detection so older instructions retire.
REQ-004 i_clk  input  1  single clock; all state updates on rising edge.
REQ-005 i_reset  input  1  asynchronous, active-high reset.
REQ-006 i_cmd_valid  input  1  command byte offered by debug link.
REQ-007 i_cmd  input  CMD_W  command: 0x52 'R' run, 0x53 'S' step, 0x48 'H' pause, 0x43 'C' clear.
REQ-008 o_cmd_ready  output  1  command accepted this cycle when high with i_cmd_valid.
REQ-009 i_halt_detected  input  1  ID stage decodes HALT opcode 6'b111111 in a valid, enabled cycle.
REQ-010 o_pipe_enable  output  1  enables PC and all pipeline registers.
REQ-011 o_pc_hold  output  1  freezes PC/IF only; later stages keep advancing.
REQ-012 o_report_valid  output  1  status report pending for debug link.
REQ-013 i_report_ready  input  1  debug link consumes report.
REQ-014 o_done  output  1  program has halted and drained.
REQ-015 o_state  output  3  current state encoding.
REQ-016 o_cycle_count  output  CNT_W  enabled-cycle count.

Function
REQ-017 States SHALL be IDLE=0, RUN=1, STEP=2, DRAIN=3, REPORT=4, DONE=5; codes 6,7 SHALL go to IDLE next cycle.
REQ-018 Command accepted only when i_cmd_valid && o_cmd_ready; o_cmd_ready high in IDLE, RUN, DONE only.
REQ-019 Accepted command not legal in current state SHALL be consumed and ignored (no state change).
REQ-020 IDLE: 'R' -> RUN; 'S' -> STEP; o_pipe_enable=0.
REQ-021 RUN: o_pipe_enable=1 every cycle; i_halt_detected -> DRAIN; else accepted 'H' -> REPORT; halt wins if both same cycle.
REQ-022 STEP: o_pipe_enable=1 for exactly one cycle; then DRAIN if i_halt_detected that cycle, else REPORT.
REQ-023 DRAIN: o_pipe_enable=1, o_pc_hold=1 for exactly DRAIN_CYCLES cycles, set internal halted flag, then REPORT.
REQ-024 REPORT: o_pipe_enable=0, o_report_valid=1 until i_report_ready sampled high; then DONE if halted flag set, else IDLE.
REQ-025 DONE: o_done=1, o_pipe_enable=0; accepted 'C' -> IDLE, clears halted flag and cycle counter.
REQ-026 o_pc_hold SHALL be 0 outside DRAIN; o_report_valid 0 outside REPORT; o_done 0 outside DONE.
REQ-027 Cycle counter SHALL increment by 1 in every cycle o_pipe_enable=1, saturating at all ones (no wrap).
REQ-028 i_halt_detected SHALL be ignored in IDLE, DRAIN, REPORT, DONE.
REQ-029 All outputs registered or decoded from state register only; no combinational path from i_cmd to o_pipe_enable.

Reset
REQ-030 i_reset high SHALL immediately force state IDLE, halted flag 0, drain counter 0, cycle counter 0.
REQ-031 During reset, o_pipe_enable=0, o_pc_hold=0, o_report_valid=0, o_done=0, o_state=0, o_cmd_ready=1.
REQ-032 Reset asserted mid-DRAIN or mid-REPORT SHALL abort the operation with no pending report retained.

Configuration
REQ-033 Macro CYCLE_COUNTER_EN defined: counter implemented per REQ-027, 'C' clears it.
REQ-034 Macro CYCLE_COUNTER_EN undefined: no counter register; o_cycle_count tied to 0; all other behaviour identical.

Verification
REQ-035 Reset, send 'R', raise i_halt_detected on 10th enabled cycle -> 4 DRAIN cycles with o_pc_hold=1, REPORT, o_cycle_count=14, o_done=1 after report handshake.
REQ-036 From IDLE send 'S' three times, report_ready held high -> exactly 3 single-cycle o_pipe_enable pulses, o_cycle_count=3, back to IDLE each time.
REQ-037 In RUN send 'H' same cycle as i_halt_detected -> DRAIN taken, not pause; after report o_done=1.
REQ-038 In REPORT hold i_report_ready low 20 cycles -> o_report_valid stays 1, o_pipe_enable 0, o_cmd_ready 0, counter frozen.
REQ-039 Assert i_reset on 2nd DRAIN cycle -> next observation all outputs at reset values, o_state=0; 'R' restarts from count 0.
REQ-040 DONE, send 'S' (ignored, state stays 5), then 'C' -> IDLE, o_cycle_count=0; without CYCLE_COUNTER_EN o_cycle_count=0 throughout.
